alu_ctrl_seq: RTL and testbench

Parametrised, registered successor to the combinational ALU control decoder. It sits at the ID/EX boundary and decodes `AluOp`/`Funct` into `ALUControl`, registering the result with a valid flag. It also tracks occupancy of the multi-cycle multiply/HI-LO unit and stalls issue of any HI/LO-class operation until that unit is free. Pipeline hold and flush are supported.

---
 rtl/alu_ctrl_seq.sv | 157 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder at the ID/EX boundary with HI/LO interlock.
// In: Clk, Rst, InValid, AluOp, Funct, Hold, Flush. Out: ALUControl, OutValid, Busy, Stall.
module alu_ctrl_seq #(
  parameter int CTRL_W  = 6,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = $clog2(MUL_LAT + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  input  logic [4:0]        AluOp,
  input  logic [5:0]        Funct,
  input  logic              Hold,
  input  logic              Flush,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              OutValid,
  output logic              Busy,
  output logic              Stall
);

  typedef enum logic {IDLE, MBUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               ovld_q, ovld_d;

  logic [5:0]         code;
  logic               is_mul;
  logic               is_hilo;
  logic               accept;

  function automatic logic [5:0] decode(
    input logic [4:0] op,
    input logic [5:0] fn
  );
    logic [5:0] r;
    r = 6'd0;
    if (op == 5'd0) begin
      case (fn)
        6'b100000: r = 6'd0;
        6'b100001: r = 6'd1;
        6'b100010: r = 6'd2;
        6'b011000: r = 6'd3;
        6'b011001: r = 6'd4;
        6'b100100: r = 6'd5;
        6'b100101: r = 6'd6;
        6'b100111: r = 6'd7;
        6'b100110: r = 6'd8;
        6'b000000: r = 6'd9;
        6'b000010: r = 6'd10;
        6'b000100: r = 6'd11;
        6'b101010: r = 6'd12;
        6'b001011: r = 6'd13;
        6'b001010: r = 6'd14;
        6'b000110: r = 6'd15;
        6'b000011: r = 6'd16;
        6'b000111: r = 6'd17;
        6'b101011: r = 6'd18;
        6'b010000: r = 6'd23;
        6'b010010: r = 6'd24;
        6'b010001: r = 6'd25;
        6'b010011: r = 6'd26;
        6'b001000: r = 6'd31;
        default:   r = 6'd0;
      endcase
    end else begin
      case (op)
        5'd1:  r = 6'd0;
        5'd2:  r = 6'd2;
        5'd3:  r = 6'd6;
        5'd4:  r = 6'd5;
        5'd5:  r = 6'd8;
        5'd6:  r = 6'd7;
        5'd7:  r = 6'd1;
        5'd8:  r = 6'd2;
        5'd9:  r = 6'd3;
        5'd10: r = 6'd12;
        5'd11: r = 6'd18;
        5'd12: begin
          case (fn)
            6'b000010: r = 6'd19;
            6'b000000: r = 6'd20;
            6'b000100: r = 6'd21;
            default:   r = 6'd0;
          endcase
        end
        5'd13: r = 6'd22;
        5'd14: r = 6'd2;
        5'd15: r = 6'd27;
        5'd16: r = 6'd28;
        5'd17: r = 6'd29;
        5'd18: r = 6'd30;
        5'd19: r = 6'd32;
        default: r = 6'd0;
      endcase
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ovld_q  <= ovld_d;
    end
  end

  // Next-state logic
  always_comb begin
    code    = decode(AluOp, Funct);
    is_mul  = (code == 6'd3) || (code == 6'd4) ||
              (code == 6'd19) || (code == 6'd20) ||
              (code == 6'd21);
    is_hilo = is_mul || (code == 6'd23) ||
              (code == 6'd24) || (code == 6'd25) ||
              (code == 6'd26);
    Stall   = InValid &
              (Hold | (is_hilo & (state_q == MBUSY)));
    accept  = InValid & ~Stall & ~Flush;

    ctrl_d = ctrl_q;
    ovld_d = ovld_q;
    if (accept) begin
      ctrl_d = CTRL_W'(code);
      ovld_d = 1'b1;
    end else if (Flush || !Hold) begin
      ovld_d = 1'b0;
    end

    // Reload wins over the countdown; countdown keeps
    // running through Hold and Flush.
    cnt_d = cnt_q;
    if (accept && is_mul) begin
      cnt_d = CNT_W'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    state_d = (cnt_d != '0) ? MBUSY : IDLE;
  end

  // Outputs
  always_comb begin
    ALUControl = ctrl_q;
    OutValid   = ovld_q;
    Busy       = (cnt_q != '0);
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: decode sweep, interlock, hold, flush, reset.
// Main DUT uses CTRL_W=8/MUL_LAT=4; a second instance checks MUL_LAT=1.
module tb_alu_ctrl_seq;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       InValid;
  logic [4:0] AluOp;
  logic [5:0] Funct;
  logic       Hold;
  logic       Flush;
  logic [7:0] ALUControl;
  logic       OutValid, Busy, Stall;
  logic [5:0] ctrl1;
  logic       ovld1, busy1, stall1;

  int n_chk = 0;
  int n_err = 0;

  int q_exp[$];
  int m_cnt;
  int m_last;
  logic m_ov;
  logic stall1_s;

  always #5 Clk = ~Clk;

  alu_ctrl_seq #(.CTRL_W(8), .MUL_LAT(4)) u_dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid),
    .AluOp(AluOp), .Funct(Funct), .Hold(Hold),
    .Flush(Flush), .ALUControl(ALUControl),
    .OutValid(OutValid), .Busy(Busy), .Stall(Stall)
  );

  alu_ctrl_seq #(.CTRL_W(6), .MUL_LAT(1)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .InValid(InValid),
    .AluOp(AluOp), .Funct(Funct), .Hold(Hold),
    .Flush(Flush), .ALUControl(ctrl1),
    .OutValid(ovld1), .Busy(busy1), .Stall(stall1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_code(input int aop, input int fn);
    int r;
    r = 0;
    if (aop == 0) begin
      case (fn)
        32: r = 0;   33: r = 1;   34: r = 2;
        24: r = 3;   25: r = 4;   36: r = 5;
        37: r = 6;   39: r = 7;   38: r = 8;
        0:  r = 9;   2:  r = 10;  4:  r = 11;
        42: r = 12;  11: r = 13;  10: r = 14;
        6:  r = 15;  3:  r = 16;  7:  r = 17;
        43: r = 18;  16: r = 23;  18: r = 24;
        17: r = 25;  19: r = 26;  8:  r = 31;
        default: r = 0;
      endcase
    end else begin
      case (aop)
        2: r = 2;   3: r = 6;   4: r = 5;
        5: r = 8;   6: r = 7;   7: r = 1;
        8: r = 2;   9: r = 3;   10: r = 12;
        11: r = 18; 13: r = 22; 14: r = 2;
        15: r = 27; 16: r = 28; 17: r = 29;
        18: r = 30; 19: r = 32;
        12: r = (fn == 2) ? 19 : (fn == 0) ? 20 :
                (fn == 4) ? 21 : 0;
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  function automatic bit is_mul(input int c);
    return c inside {3, 4, 19, 20, 21};
  endfunction

  function automatic bit is_hilo(input int c);
    return is_mul(c) || (c inside {23, 24, 25, 26});
  endfunction

  task automatic step(input logic v, input int aop,
                      input int fn, input logic h,
                      input logic f);
    int   code;
    logic exp_st;
    logic acc;
    int   e;
    @(negedge Clk);
    InValid = v;
    AluOp   = 5'(aop);
    Funct   = 6'(fn);
    Hold    = h;
    Flush   = f;
    #1;
    code   = ref_code(aop, fn);
    exp_st = v && (h || (is_hilo(code) && m_cnt != 0));
    chk("stall", Stall, exp_st);
    stall1_s = stall1;
    acc = v && !exp_st && !f;
    if (acc) q_exp.push_back(code);
    if (acc) m_ov = 1'b1;
    else if (f || !h) m_ov = 1'b0;
    if (acc && is_mul(code)) m_cnt = 4;
    else if (m_cnt > 0) m_cnt--;
    @(posedge Clk);
    #1;
    chk("ovld", OutValid, m_ov);
    chk("busy", Busy, m_cnt != 0);
    if (acc) begin
      e = q_exp.pop_front();
      m_last = e;
      chk("ctrl", ALUControl, e);
    end else begin
      chk("ctrl_hold", ALUControl, m_last);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && m_cnt != 0; i++)
      step(0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_last = 0;
    m_ov   = 1'b0;
    q_exp.delete();
  endtask

  initial begin
    int n;
    InValid = 0; AluOp = 0; Funct = 0;
    Hold = 0; Flush = 0;
    Rst = 1;
    model_reset();
    #12;
    chk("rst_ctrl", ALUControl, 0);
    chk("rst_ovld", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_stall", Stall, 0);
    @(negedge Clk);
    Rst = 0;

    // Full decode sweep
    for (int a = 0; a < 32; a++) begin
      for (int fn = 0; fn < 64; fn++) begin
        step(1, a, fn, 0, 0);
        drain();
      end
    end
    step(1, 19, 0, 0, 0);
    chk("ctrl_hi", 32'(ALUControl[7:6]), 0);

    // mult then mflo: 4 stall cycles
    step(1, 0, 24, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 18, 0, 0);
      if (m_ov && m_last == 24) break;
      n++;
    end
    chk("mflo_stalls", n, 4);
    chk("mflo_code", ALUControl, 24);

    // add during Busy issues
    step(1, 0, 24, 0, 0);
    step(1, 0, 32, 0, 0);
    step(1, 0, 37, 0, 0);
    drain();

    // Hold with InValid and AluOp 3
    step(1, 3, 0, 0, 0);
    step(1, 2, 0, 1, 0);
    step(1, 2, 0, 1, 0);
    step(1, 2, 0, 1, 0);
    step(1, 3, 0, 0, 0);
    chk("hold_rel", ALUControl, 6);
    // Hold while a multiply counts down
    step(1, 0, 25, 0, 0);
    step(1, 0, 32, 1, 0);
    step(1, 0, 32, 1, 0);
    step(1, 0, 32, 1, 0);
    drain();

    // Flush vs accept
    step(1, 12, 0, 0, 1);
    chk("flush_busy", Busy, 0);
    step(1, 9, 0, 0, 0);
    step(1, 5, 0, 0, 1);
    step(1, 0, 16, 0, 1);
    step(1, 0, 32, 1, 1);
    drain();

    // MUL_LAT=1: multu then mfhi stalls one cycle
    step(1, 0, 25, 0, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 16, 0, 0);
      if (stall1_s) n++;
    end
    chk("lat1_stalls", n, 1);
    chk("lat1_code", ctrl1, 23);
    drain();

    // Async reset with counter at 3
    step(1, 0, 24, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst_cnt", m_cnt, 3);
    #2;
    Rst = 1;
    #1;
    model_reset();
    chk("arst_ctrl", ALUControl, 0);
    chk("arst_ovld", OutValid, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_stall", Stall, 0);
    @(negedge Clk);
    Rst = 0;
    step(1, 19, 0, 0, 0);
    chk("post_rst", ALUControl, 32);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
